nn_act_requant: RTL and testbench
=================================

# nn_act_requant

Post-processing stage directly downstream of `nn_accelerator`. It consumes the per-neuron `ACC_WIDTH` dot-product stream and adds an optional bias. It then applies optional ReLU, a rounding arithmetic right shift and saturation, producing a `DATA_WIDTH` stream. Results are buffered in a small FIFO and emitted with a layer-end marker, so the output can feed the next layer's `in_*` input port.

## Interface

**Parameters** (name, default, meaning):
- `DATA_W`, `` `DATA_WIDTH ``, output element width (signed).
- `ACC_W`, `` `ACC_WIDTH ``, accumulator input width (signed).
- `FIFO_DEPTH`, 8, output buffer entries (power of 2, ≥ 4).

**Ports** (name, direction, width, meaning):
- `clk`, in, 1, single clock, rising edge.
- `rstn`, in, 1, synchronous active-low reset.
- `start`, in, 1, one-cycle pulse that begins a layer; honoured only in IDLE.
- `neuron_count`, in, 16, results expected this layer; latched on `start`.
- `shift`, in, 5, right-shift amount; latched on `start`.
- `relu_en`, in, 1, clamp negatives to 0; latched on `start`.
- `acc_valid`, in, 1, accumulator word valid.
- `acc_data`, in, `ACC_W`, signed accumulator.
- `acc_ready`, out, 1, stage accepts `acc_data`.
- `bias_valid`, in, 1, bias word valid (present only with `ACT_BIAS_EN`).
- `bias_data`, in, `ACC_W`, signed bias (present only with `ACT_BIAS_EN`).
- `bias_ready`, out, 1, bias accepted (present only with `ACT_BIAS_EN`).
- `out_valid`, out, 1, result valid.
- `out_data`, out, `DATA_W`, signed requantized result.
- `out_last`, out, 1, high with the result for neuron index `neuron_count-1`.
- `out_ready`, in, 1, downstream accepts.
- `busy`, out, 1, high outside IDLE.
- `done`, out, 1, one-cycle pulse when the layer fully drains.

## Operation

**States**
- IDLE → RUN on `start`. The latch captures `neuron_count`/`shift`/`relu_en`, clears the neuron counter, and the FIFO is empty.
- IDLE → DONE on `start` with `neuron_count==0`.
- RUN → DRAIN once `neuron_count` accumulators have been accepted.
- DRAIN → DONE when both pipeline stages are empty and the FIFO is empty, i.e. the last result has been popped.
- DONE → IDLE unconditionally. `done` is asserted for that one cycle.

**Input handshake**
- `acc_ready = (state==RUN) && (fifo_count + inflight < FIFO_DEPTH)`, where `inflight` counts valid pipeline stages. This credit scheme means the FIFO can never overflow.
- With the bias feature enabled, both streams are joined: `acc_ready` and `bias_ready` are asserted together, and both words are consumed only when `acc_valid && bias_valid`.

**Datapath** (internal width `ACC_W+1`, no intermediate overflow)
- Stage 1: `s = acc + bias`, with bias sign-extended; without bias, `s = acc`.
- Stage 2:
  - If `relu_en && s<0`, then `s=0`.
  - If `shift>0`, then `r = (s + (1<<(shift-1))) >>> shift`; otherwise `r = s`. Rounding is half toward +∞.
  - Saturate `r` to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Push `r` to the FIFO together with the `last` flag.

**Control behaviour**
- `start` outside IDLE is ignored.
- Inputs offered outside RUN are not accepted.
- FIFO push and pop in the same cycle are legal in all occupancy states.

## Timing

- **Reset values:** `acc_ready`=0, `bias_ready`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0. State = IDLE, FIFO empty, pipeline cleared.
- **Reset mid-operation:** discards all buffered and in-flight results. No `done` is issued.
- **Latency:** an accumulator handshaken at edge N is written to the FIFO at edge N+2. With the FIFO empty, `out_valid` is high in the cycle after edge N+2.
- **Throughput:** one result per cycle when `out_ready=1`.
- **Output hold:** `out_data`/`out_last` are held stable while `out_valid && !out_ready`.
- **Start latch:** `acc_ready` can first assert in the cycle after `start` is sampled.
- **`done` timing:** asserts in the cycle after the last FIFO pop; `busy` falls one cycle later.

## Configuration

- **`ACT_BIAS_EN` defined:**
  - `bias_valid`/`bias_data`/`bias_ready` ports exist.
  - The bias add is performed in stage 1.
  - Input consumption requires both streams valid.
- **`ACT_BIAS_EN` undefined:**
  - The bias ports are absent and stage 1 passes `acc` through.
  - Latency and timing are identical.

## Test plan

- **Pass-through:** `neuron_count=4`, `shift=0`, `relu_en=0`, no bias, `acc` = 204, 408, 612, 816 → outputs 204, 408, 612, 816 in order; `out_last` only on 816; `done` one cycle after the final pop.
- **Rounding:** `shift=2`, `relu_en=0`, `acc` = 7, −7, 6, −6 → outputs 2, −2, 2, −1.
- **Saturation and ReLU:** `DATA_W=16`, `shift=0`, `acc` = 40000, −40000 → 32767, −32768; same inputs with `relu_en=1` → 32767, 0.
- **Backpressure:** `FIFO_DEPTH=8`, `neuron_count=10`, `out_ready=0`, `acc_valid` held high → exactly 8 accepted, then `acc_ready`=0; release `out_ready` → all 10 emitted in order, with no loss or duplication.
- **Empty layer:** `neuron_count=0` with a `start` pulse → no `acc_ready`, no `out_valid`; `done` pulses in the cycle after `start`; a second `start` during RUN is ignored.
- **Reset mid-run and bias:** `rstn`=0 for one cycle after 3 of 4 results → all outputs return to reset values and the FIFO is empty. With `ACT_BIAS_EN`, `acc`=100, `bias`=−150, `relu_en=1` → 0; with `bias_valid`=0, `acc` is not consumed.

Source files
------------

// File: rtl/nn_act_requant.sv
// Activation/requantization stage: bias add, ReLU, rounding shift, saturation, output FIFO.
// Latency: accumulator accepted at edge N is written to the FIFO at edge N+2.
// Backpressure: credit-based acc_ready (FIFO + in-flight < depth), so a stalled out_ready never overflows the FIFO.
//
// Ports: clk/rstn (sync active-low); start/neuron_count/shift/relu_en latched in IDLE;
//   acc_valid/acc_data/acc_ready input stream; bias_valid/bias_data/bias_ready when
//   ACT_BIAS_EN is defined; out_valid/out_data/out_last/out_ready output stream; busy, done.
// Optional feature macro: ACT_BIAS_EN (adds the joined bias stream and the stage-1 bias add).

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

// Small generic synchronous FIFO; registered count, read data gated to zero when empty.
// Latency: a push is visible at the output in the cycle after the push edge.
// Backpressure: none internally; caller must never push when full nor pop when empty.
module nn_act_requant_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic                       vld,
    output logic [W-1:0]               dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign vld = (count != '0);
    // Zero when empty so out_data reads 0 after reset instead of stale storage.
    assign dat = vld ? mem[rd_ptr] : '0;
endmodule

module nn_act_requant #(
    parameter int DATA_W     = `DATA_WIDTH,
    parameter int ACC_W      = `ACC_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [15:0]              neuron_count,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    input  logic                     acc_valid,
    input  logic signed [ACC_W-1:0]  acc_data,
    output logic                     acc_ready,
`ifdef ACT_BIAS_EN
    input  logic                     bias_valid,
    input  logic signed [ACC_W-1:0]  bias_data,
    output logic                     bias_ready,
`endif
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [ACC_W+1:0] SAT_MAX =
        {{(ACC_W+3-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W+1:0] SAT_MIN =
        {{(ACC_W+3-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W+1:0] ONE = {{(ACC_W+1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state;
    logic [15:0] n_q;
    logic [15:0] cnt;
    logic [4:0]  shift_q;
    logic        relu_q;

    // Pipeline registers
    logic                     s1_vld;
    logic signed [ACC_W:0]    s1_sum;
    logic                     s1_last;
    logic                     s2_vld;
    logic [DATA_W-1:0]        s2_dat;
    logic                     s2_last;

    // FIFO interface
    logic              f_vld;
    logic [DATA_W:0]   f_dat;
    logic [AW:0]       f_count;
    logic              f_pop;

    logic              in_ready;
    logic              in_fire;
    logic [AW:0]       occ;
    logic              drain_done;
    logic signed [ACC_W:0] sum;

    // Credits: everything already in the FIFO plus everything still in the pipe.
    always_comb begin
        occ = f_count + (AW+1)'(s1_vld) + (AW+1)'(s2_vld);
    end

    assign in_ready = (state == RUN) && (occ < DEPTH_C);
    assign acc_ready = in_ready;

`ifdef ACT_BIAS_EN
    assign bias_ready = in_ready;
    assign in_fire    = in_ready && acc_valid && bias_valid;
    assign sum = {acc_data[ACC_W-1], acc_data} + {bias_data[ACC_W-1], bias_data};
`else
    assign in_fire    = in_ready && acc_valid;
    assign sum = {acc_data[ACC_W-1], acc_data};
`endif

    assign f_pop = f_vld && out_ready;

    // Leave DRAIN on the edge that pops the final entry so done lands in the next cycle.
    assign drain_done = !s1_vld && !s2_vld &&
                        ((f_count == '0) || ((f_count == (AW+1)'(1)) && f_pop));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            n_q     <= '0;
            cnt     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_q     <= neuron_count;
                        shift_q <= shift;
                        relu_q  <= relu_en;
                        cnt     <= '0;
                        state   <= (neuron_count == 16'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        cnt <= cnt + 16'd1;
                        if (cnt == n_q - 16'd1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drain_done) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Stage 2 combinational: ReLU, rounding shift (half toward +inf), saturation.
    // Two guard bits above ACC_W so the rounding add cannot wrap.
    logic signed [ACC_W+1:0] t;
    logic signed [ACC_W+1:0] half;
    logic signed [ACC_W+1:0] rnd;
    logic [DATA_W-1:0]       sat;

    always_comb begin
        t    = {s1_sum[ACC_W], s1_sum};
        half = '0;
        rnd  = '0;
        sat  = '0;
        if (relu_q && t[ACC_W+1]) t = '0;
        if (shift_q != 5'd0) begin
            half = ONE << (shift_q - 5'd1);
            rnd  = (t + half) >>> shift_q;
        end else begin
            rnd = t;
        end
        if (rnd > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
        else if (rnd < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
        else                    sat = rnd[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_vld  <= 1'b0;
            s1_sum  <= '0;
            s1_last <= 1'b0;
            s2_vld  <= 1'b0;
            s2_dat  <= '0;
            s2_last <= 1'b0;
        end else begin
            s1_vld <= in_fire;
            if (in_fire) begin
                s1_sum  <= sum;
                s1_last <= (cnt == n_q - 16'd1);
            end
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_dat  <= sat;
                s2_last <= s1_last;
            end
        end
    end

    nn_act_requant_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (s2_vld),
        .push_dat ({s2_last, s2_dat}),
        .pop      (f_pop),
        .vld      (f_vld),
        .dat      (f_dat),
        .count    (f_count)
    );

    assign out_valid = f_vld;
    assign out_last  = f_dat[DATA_W];
    assign out_data  = f_dat[DATA_W-1:0];
endmodule

// File: tb/tb_nn_act_requant.sv
module tb_nn_act_requant;
    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic [15:0]        neuron_count;
    logic [4:0]         shift;
    logic               relu_en;
    logic               acc_valid;
    logic signed [31:0] acc_data;
    logic               acc_ready;
`ifdef ACT_BIAS_EN
    logic               bias_valid = 1'b1;
    logic signed [31:0] bias_data  = '0;
    logic               bias_ready;
`endif
    logic               out_valid;
    logic signed [15:0] out_data;
    logic               out_last;
    logic               out_ready;
    logic               busy;
    logic               done;

    int checks = 0;
    int errors = 0;
    int vals [0:15];
    int expv [0:15];

    always #5 clk = ~clk;

    nn_act_requant #(.DATA_W(16), .ACC_W(32), .FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .neuron_count (neuron_count),
        .shift        (shift),
        .relu_en      (relu_en),
        .acc_valid    (acc_valid),
        .acc_data     (acc_data),
        .acc_ready    (acc_ready),
`ifdef ACT_BIAS_EN
        .bias_valid   (bias_valid),
        .bias_data    (bias_data),
        .bias_ready   (bias_ready),
`endif
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expd);
        end
    endtask

    // Drive a start pulse sampled at the next rising edge.
    task automatic pulse_start(input int n, input int sh, input bit relu);
        @(negedge clk);
        start        = 1'b1;
        neuron_count = 16'(n);
        shift        = 5'(sh);
        relu_en      = relu;
        @(posedge clk);
    endtask

    // Run one layer: feed vals[0..n-1], stall the output for `hold` cycles,
    // check each output against expv[], then check the done/busy tail.
    // With restart set, a second start pulse (neuron_count=5) arrives mid-RUN.
    task automatic run_layer(input int n, input int sh, input bit relu,
                             input int hold, input bit restart);
        int ai, oi, cyc, first_acc, first_out;
        ai = 0; oi = 0; cyc = 0; first_acc = -1; first_out = -1;
        pulse_start(n, sh, relu);
        while (oi < n && cyc < 300) begin
            @(negedge clk);
            start = restart && (cyc == 1);
            if (restart) neuron_count = 16'd5;
            if (hold > 0 && cyc == hold) begin
                chk("bp_accepted", ai, 8);
                chk("bp_ready_low", acc_ready, 0);
            end
            out_ready = (cyc >= hold);
            acc_valid = (ai < n);
            acc_data  = vals[ai & 15];
            #1;
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = cyc;
                chk("out_data", out_data, expv[oi]);
                chk("out_last", out_last, (oi == n - 1));
                oi++;
            end
            if (acc_valid && acc_ready) begin
                if (first_acc < 0) first_acc = cyc;
                ai++;
            end
            cyc++;
        end
        acc_valid = 1'b0;
        start     = 1'b0;
        chk("outputs_seen", oi, n);
        chk("inputs_taken", ai, n);
        if (hold == 0) chk("latency", first_out - first_acc, 3);
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("done_cleared", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; neuron_count = '0; shift = '0; relu_en = 1'b0;
        acc_valid = 1'b0; acc_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_acc_ready", acc_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;

        // Pass-through
        vals[0] = 204; vals[1] = 408; vals[2] = 612; vals[3] = 816;
        expv[0] = 204; expv[1] = 408; expv[2] = 612; expv[3] = 816;
        run_layer(4, 0, 1'b0, 0, 1'b0);

        // Rounding, shift=2
        vals[0] = 7; vals[1] = -7; vals[2] = 6; vals[3] = -6;
        expv[0] = 2; expv[1] = -2; expv[2] = 2; expv[3] = -1;
        run_layer(4, 2, 1'b0, 0, 1'b0);

        // Saturation, then saturation with ReLU
        vals[0] = 40000; vals[1] = -40000;
        expv[0] = 32767; expv[1] = -32768;
        run_layer(2, 0, 1'b0, 0, 1'b0);
        expv[1] = 0;
        run_layer(2, 0, 1'b1, 0, 1'b0);

        // Larger shift with rounding up across a half boundary
        vals[0] = 1000; vals[1] = -1000;
        expv[0] = 63; expv[1] = -62;
        run_layer(2, 4, 1'b0, 0, 1'b0);

        // Backpressure: 10 results, FIFO of 8, output stalled for 20 cycles
        for (int i = 0; i < 10; i++) begin
            vals[i] = 100 + 3 * i;
            expv[i] = 100 + 3 * i;
        end
        run_layer(10, 0, 1'b0, 20, 1'b0);

        // Empty layer
        pulse_start(0, 0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_acc_ready", acc_ready, 0);
        chk("empty_out_valid", out_valid, 0);
        @(negedge clk);
        chk("empty_done_clr", done, 0);
        chk("empty_out_valid2", out_valid, 0);

        // Start during RUN is ignored: layer keeps its latched count of 2
        vals[0] = -5; vals[1] = 9;
        expv[0] = -5; expv[1] = 9;
        run_layer(2, 0, 1'b0, 0, 1'b1);

        // Reset mid-run after 3 of 4 results sit in the FIFO
        pulse_start(4, 0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc_valid = 1'b1;
            acc_data  = 11 * (i + 1);
            @(negedge clk);
        end
        acc_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_busy", busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_acc_ready", acc_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_done", done, 0);
            chk("post_rst_empty", out_valid, 0);
        end

        // Fresh layer after reset sees an empty FIFO
        vals[0] = 77; vals[1] = -88;
        expv[0] = 77; expv[1] = -88;
        run_layer(2, 0, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
